digit_counter: RTL and testbench
================================

DIGIT_COUNTER -- requirements
Module: digit_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of start_count and count.
REQ-002 Parameter MAX, default 9: highest legal digit value; the digit range is 0..MAX.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  count-step qualifier: one step per clk edge while high.
REQ-006 direction  input  1  0 = count down, 1 = count up.
REQ-007 start_count  input  WIDTH  value loaded into count on reset.
REQ-008 count  output  WIDTH  registered digit value.
REQ-009 zero_count  output  1  high while count == 0.

Function
REQ-010 On a clk edge with reset=0 and enable=0, count SHALL hold.
REQ-011 On a clk edge with reset=0, enable=1, direction=0 and count>0, count SHALL become count-1.
REQ-012 On a clk edge with reset=0, enable=1, direction=0 and count==0, count SHALL wrap to MAX.
REQ-013 On a clk edge with reset=0, enable=1, direction=1 and count<MAX, count SHALL become count+1.
REQ-014 On a clk edge with reset=0, enable=1, direction=1 and count==MAX, count SHALL wrap to 0.
REQ-015 direction SHALL be sampled on each enabled edge; a change takes effect on the next enabled step without reloading or otherwise disturbing count.
REQ-016 zero_count SHALL be combinational from count (count==0), with no extra latency and independent of enable and direction.
REQ-017 Arithmetic SHALL be WIDTH bits wide with explicit wrap at MAX/0; count SHALL never leave the range 0..MAX after a reset.
REQ-018 Simultaneous reset=1 and enable=1: reset SHALL win.

Reset
REQ-019 On a clk edge with reset=1, count SHALL load start_count; if start_count > MAX, count SHALL load MAX.
REQ-020 Reset asserted mid-count SHALL abort the sequence and reload per REQ-019 on that same edge.
REQ-021 After reset, zero_count SHALL be 1 if and only if the loaded value is 0.
REQ-022 There SHALL be no asynchronous reset path.

Structure
REQ-023 No shared package is needed; WIDTH and MAX are module parameters only.
REQ-024 The companion module clock_divider SHALL be delivered with digit_counter. It generates the enable strobe and has the following definition:
  - Parameters: MAX_COUNT (default 4_999_999) and CTR_WIDTH (default 23).
  - Ports: clk (input, 1), reset (input, 1, synchronous active-high), pulse (output, 1).
REQ-025 clock_divider behaviour:
  - An internal CTR_WIDTH-bit counter SHALL run 0..MAX_COUNT and then wrap to 0.
  - pulse SHALL be high for exactly one cycle when the counter equals MAX_COUNT, giving a period of MAX_COUNT+1 clocks.
  - Reset SHALL clear the counter to 0 and hold pulse at 0.
REQ-026 The integrator SHALL choose CTR_WIDTH large enough to hold MAX_COUNT; the module does no width checking.

Verification
REQ-027 Reset with start_count=9, direction=0, enable from clock_divider with MAX_COUNT=9 -> count=9 after reset; first pulse 10 clocks after reset release; count steps 9,8,...,1,0,9 at one step per 10 clocks.
REQ-028 Down-count reaching 0 -> zero_count=1 for the full 10-clock dwell at 0, then count wraps to 9 and zero_count=0.
REQ-029 Mid-sequence reset (count=4) -> count=9 on the reset edge; clock_divider counter restarts, so the next pulse comes 10 clocks after release.
REQ-030 Switch direction to 1 while count=3 -> subsequent steps 4,5,...,9,0,1.
REQ-031 start_count=12 with MAX=9, reset -> count=9; enable held at 0 -> count holds 9 indefinitely.
REQ-032 reset=1 and enable=1 on the same edge with count=5, start_count=7 -> count=7.

Source files
------------

// File: rtl/digit_counter_pkg.sv
// Shared type definitions for the digit counter slice.
// Only names the count direction; WIDTH and MAX stay module parameters.
package digit_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/clock_divider.sv
// Strobe generator: pulse is high for one clock every MAX_COUNT+1 clocks.
// CTR_WIDTH must be wide enough to hold MAX_COUNT.
module clock_divider #(
  parameter int MAX_COUNT = 4_999_999,
  parameter int CTR_WIDTH = 23
) (
  input  logic clk,
  input  logic reset,
  output logic pulse
);

  localparam logic [CTR_WIDTH-1:0] LAST = CTR_WIDTH'(MAX_COUNT);

  logic [CTR_WIDTH-1:0] ctr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr <= '0;
    end else if (ctr == LAST) begin
      ctr <= '0;
    end else begin
      ctr <= ctr + CTR_WIDTH'(1);
    end
  end

  // Gated by reset so the strobe cannot escape while the counter is being cleared.
  assign pulse = (ctr == LAST) && !reset;

endmodule

// File: rtl/digit_counter.sv
// Single up/down digit counter over 0..MAX with wrap at both ends.
// Reset loads start_count, clamped to MAX so the count never leaves range.
module digit_counter
  import digit_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             direction,
  input  logic [WIDTH-1:0] start_count,
  output logic [WIDTH-1:0] count,
  output logic             zero_count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  dir_e dir;
  assign dir = dir_e'(direction);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of count; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= (start_count > MAX_V) ? MAX_V : start_count;
    end else if (enable) begin
      if (dir == DIR_UP) begin
        count <= (count >= MAX_V) ? '0 : count + WIDTH'(1);
      end else begin
        count <= (count == '0 || count > MAX_V) ? MAX_V : count - WIDTH'(1);
      end
    end
  end

  assign zero_count = (count == '0);

endmodule

// File: tb/tb_digit_counter.sv
// Scoreboard bench for digit_counter driven either manually or by clock_divider.
// Stimulus queues expected post-edge values; a monitor pops and compares them.
module tb_digit_counter;

  localparam int WIDTH = 4;
  localparam int MAX   = 9;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic             zero;
    logic             chk_pulse;
    logic             pulse;
    string            name;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             direction;
  logic             man_en;
  logic             use_div;
  logic             pulse;
  logic [WIDTH-1:0] start_count;
  logic [WIDTH-1:0] count;
  logic             zero_count;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign enable = use_div ? pulse : man_en;

  digit_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .direction   (direction),
    .start_count (start_count),
    .count       (count),
    .zero_count  (zero_count)
  );

  clock_divider #(.MAX_COUNT(9), .CTR_WIDTH(4)) div (
    .clk   (clk),
    .reset (reset),
    .pulse (pulse)
  );

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus with its hand-computed post-edge expectation.
  task automatic step(input logic r, input logic en, input logic dir,
                      input logic [WIDTH-1:0] st, input logic [WIDTH-1:0] exp_cnt,
                      input logic chk_p, input logic exp_p, input string nm);
    exp_t e;
    @(negedge clk);
    reset       = r;
    man_en      = en;
    direction   = dir;
    start_count = st;
    e.cnt       = exp_cnt;
    e.zero      = (exp_cnt == '0);
    e.chk_pulse = chk_p;
    e.pulse     = exp_p;
    e.name      = nm;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Divider-driven down count from 9: after k edges since release the
  // counter has taken k/10 steps and the strobe is up when k%10 == 9.
  task automatic run_div(input int n, input string nm);
    for (int k = 1; k <= n; k++) begin
      step(1'b0, 1'b0, 1'b0, 4'd9, WIDTH'(9 - ((k / 10) % 10)),
           1'b1, (k % 10) == 9, nm);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".count"}, int'(count), int'(e.cnt));
        check({e.name, ".zero"}, int'(zero_count), int'(e.zero));
        if (e.chk_pulse) check({e.name, ".pulse"}, int'(pulse), int'(e.pulse));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int drain;
    reset       = 1'b1;
    man_en      = 1'b0;
    direction   = 1'b0;
    start_count = 4'd9;
    use_div     = 1'b1;

    // Divider-driven: 9 down to 0, 10-clock dwell at 0, wrap back to 9.
    step(1'b1, 1'b0, 1'b0, 4'd9, 4'd9, 1'b1, 1'b0, "rst9");
    run_div(105, "div_down");

    // Mid-sequence reset at count 4 reloads 9 and restarts the divider.
    step(1'b1, 1'b0, 1'b0, 4'd9, 4'd9, 1'b1, 1'b0, "rst_a");
    run_div(55, "div_to4");
    step(1'b1, 1'b0, 1'b0, 4'd9, 4'd9, 1'b1, 1'b0, "rst_mid");
    run_div(12, "div_restart");

    // Manual enable: count down to 3, hold, then switch direction up.
    use_div = 1'b0;
    step(1'b1, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0, "rst5");
    step(1'b0, 1'b1, 1'b0, 4'd5, 4'd4, 1'b0, 1'b0, "dn4");
    step(1'b0, 1'b1, 1'b0, 4'd5, 4'd3, 1'b0, 1'b0, "dn3");
    step(1'b0, 1'b0, 1'b1, 4'd5, 4'd3, 1'b0, 1'b0, "hold3");
    step(1'b0, 1'b1, 1'b1, 4'd5, 4'd4, 1'b0, 1'b0, "up4");
    step(1'b0, 1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, "up5");
    step(1'b0, 1'b1, 1'b1, 4'd5, 4'd6, 1'b0, 1'b0, "up6");
    step(1'b0, 1'b1, 1'b1, 4'd5, 4'd7, 1'b0, 1'b0, "up7");
    step(1'b0, 1'b1, 1'b1, 4'd5, 4'd8, 1'b0, 1'b0, "up8");
    step(1'b0, 1'b1, 1'b1, 4'd5, 4'd9, 1'b0, 1'b0, "up9");
    step(1'b0, 1'b1, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0, "up_wrap0");
    step(1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 1'b0, 1'b0, "up1");

    // Out-of-range start values clamp to MAX and hold with enable low.
    step(1'b1, 1'b0, 1'b0, 4'd12, 4'd9, 1'b0, 1'b0, "rst12");
    step(1'b0, 1'b0, 1'b1, 4'd12, 4'd9, 1'b0, 1'b0, "hold9a");
    step(1'b0, 1'b0, 1'b0, 4'd12, 4'd9, 1'b0, 1'b0, "hold9b");
    step(1'b0, 1'b0, 1'b1, 4'd12, 4'd9, 1'b0, 1'b0, "hold9c");
    step(1'b1, 1'b0, 1'b0, 4'd15, 4'd9, 1'b0, 1'b0, "rst15");

    // Reset beats enable; zero load and both wrap directions from 0.
    step(1'b1, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0, "rst5b");
    step(1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, "rst_wins");
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "rst0");
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, "dn_wrap9");
    step(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "up_wrap0b");
    step(1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, "up1b");

    @(negedge clk);
    man_en = 1'b0;
    drain  = 0;
    while (exp_q.size() > 0 && drain < 5) begin
      @(posedge clk);
      #2;
      drain++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
